fft_input_framer: RTL and testbench
===================================

Name: fft_input_framer

Overview:
- Collects a serial stream of signed 16-bit audio samples into 32-sample frames.
- Reorders each frame into bit-reversed order and presents it as one parallel 512-bit word with a single-cycle valid pulse.
- Sits directly upstream of the first radix-2 butterfly level: slot k drives that level's in_k, frame_valid drives its valid.
- Double-buffered, so a new frame can be filled while the previous one is held on the outputs.

Parameters:
- N_PTS, 32, samples per frame; must be a power of two; index width is log2(N_PTS) = 5.
- DATA_W, 16, sample width in bits, two's complement.
- PRESHIFT, 0, arithmetic right shift applied to each sample on capture; provides overflow headroom for the butterfly levels.

Ports:
- clk_100MHz  in  1  system clock; all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- s_data  in  DATA_W  input sample, signed.
- s_valid  in  1  s_data is valid this cycle.
- s_ready  out  1  framer accepts s_data this cycle.
- s_sof  in  1  start-of-frame marker, qualified by s_valid && s_ready.
- frame_data  out  N_PTS*DATA_W  output frame; slot k occupies bits [16k+15:16k].
- frame_valid  out  1  one-cycle pulse: frame_data has just been updated.
- wr_count  out  6  samples accepted in the current partial frame, 0..31.
- frame_err  out  1  sticky flag: a partial frame was discarded.
- clr_err  in  1  synchronous clear of frame_err.

Behaviour:
- Reset (async assert, sync-released internally by clock edge):
  - frame_data=0, frame_valid=0, wr_count=0, frame_err=0, s_ready=0; state=IDLE.
- Accept: a sample is accepted when s_valid && s_ready. s_ready is 1 in every state except IDLE.
- State machine:
  - IDLE: entered on reset. Moves to FILL on the first clock after reset release. s_ready is asserted from the FILL state onward, so it goes high one cycle after reset release.
  - FILL: each accepted sample, after the PRESHIFT arithmetic shift with sign preserved, is written to the write buffer at address bitrev5(wr_count); wr_count then increments.
  - On the accept with wr_count==31: the complete write buffer, including the sample just accepted (bypassed into slot bitrev5(31)=31), is copied to the frame_data register at the next edge. frame_valid is 1 in that following cycle only. wr_count wraps to 0. State returns to FILL; there is no separate emit-wait state.
- Latency: frame_data and frame_valid are visible exactly 1 cycle after the 32nd sample's accepting edge.
- Back-to-back frames are allowed: a sample accepted in the frame_valid cycle goes to index 0 of the next frame. frame_data holds until the next full frame completes.
- Bit reversal: slot k of frame_data holds sample number bitrev5(k) of the frame, where sample 0 is the first accepted.
- s_sof handling:
  - s_sof accepted with wr_count==0: normal start of frame.
  - s_sof accepted with wr_count!=0: the partial frame is discarded, frame_err is set, and the sample is stored as sample 0 (wr_count becomes 1). frame_data is not disturbed.
  - s_sof is ignored when not accepted.
- frame_err: set as above; cleared by clr_err. If set and clear occur in the same cycle, set wins.
- Stale slots: the write buffer is not cleared between frames. Every slot is rewritten before each emit, so stale data is never visible on frame_data.
- s_valid low: no state change, and no timeout on partial frames.
- Reset mid-frame: the partial frame is lost, frame_data returns to 0, and no frame_valid is produced.
- Size: the write buffer is 32 x DATA_W flops; frame_data is a separate 512-bit register. No RAM inference is required.

Test Plan:
- Reset then stream 0..31 with s_valid held high → frame_valid pulses once, 1 cycle after the 32nd accept. Required slot values: slot0=0, slot1=16, slot2=8, slot3=24, slot16=1, slot31=31. wr_count returns to 0.
- Two frames back-to-back with no gap (frame A = 100+i, frame B = -i) → two pulses exactly 32 cycles apart. During frame B fill, slot1 holds 116; after the second pulse, slot1=-16 (16'hFFF0).
- s_valid toggled randomly across a frame → identical frame_data to the gapless case. The pulse follows only the 32nd accept.
- After 10 samples, an s_sof accept with value 7 → frame_err=1 and wr_count=1. After 31 more samples, slot0=7 and a frame_valid pulse occurs. clr_err in a later cycle → frame_err=0.
- PRESHIFT=1 with input -3 in every position → every slot = -2 (16'hFFFE), confirming the shift is arithmetic.
- Assert rstn low after 20 samples → all outputs 0 immediately (asynchronous). After release, 32 new samples give exactly one pulse, with no residue from the aborted frame.

Source files
------------

// File: rtl/fft_input_framer.sv
// Serial-to-parallel framer for the FFT front end: gathers 32 signed samples,
// stores them bit-reversed and emits one 512-bit frame with a one-cycle valid.
module fft_input_framer #(
    parameter int N_PTS    = 32,
    parameter int DATA_W   = 16,
    parameter int PRESHIFT = 0
) (
    input  logic                           clk_100MHz,
    input  logic                           rstn,
    input  logic signed [DATA_W-1:0]       s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    input  logic                           s_sof,
    output logic [N_PTS*DATA_W-1:0]        frame_data,
    output logic                           frame_valid,
    output logic [$clog2(N_PTS):0]         wr_count,
    output logic                           frame_err,
    input  logic                           clr_err
);

    localparam int IDX_W = $clog2(N_PTS);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } state_t;

    state_t                  r_state;
    state_t                  w_nextState;
    logic                    w_ready;

    logic [CNT_W-1:0]        r_wrCount;
    logic [CNT_W-1:0]        w_nextCount;
    logic [DATA_W-1:0]       r_wrBuf [N_PTS];
    logic [N_PTS*DATA_W-1:0] r_frameData;
    logic                    r_frameValid;
    logic                    r_frameErr;

    logic                    w_accept;
    logic                    w_sofRestart;
    logic                    w_lastAccept;
    logic [IDX_W-1:0]        w_wrAddr;
    logic signed [DATA_W-1:0] w_shifted;

    function automatic logic [IDX_W-1:0] bitRev(input logic [IDX_W-1:0] a);
        logic [IDX_W-1:0] r;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = a[IDX_W-1-i];
        end
        return r;
    endfunction

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // IDLE only exists to hold s_ready low for the first cycle after reset release.
    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_nextState = ST_FILL;
            end
            ST_FILL: begin
                w_ready     = 1'b1;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    assign w_accept     = s_valid && w_ready;
    assign w_sofRestart = w_accept && s_sof && (r_wrCount != '0);
    assign w_lastAccept = w_accept && !w_sofRestart && (r_wrCount == CNT_W'(N_PTS - 1));
    assign w_wrAddr     = w_sofRestart ? '0 : bitRev(r_wrCount[IDX_W-1:0]);
    assign w_shifted    = s_data >>> PRESHIFT;

    // A restarting s_sof sample becomes sample 0 of a fresh frame.
    always_comb begin
        w_nextCount = r_wrCount;
        if (w_sofRestart) begin
            w_nextCount = CNT_W'(1);
        end else if (w_lastAccept) begin
            w_nextCount = '0;
        end else if (w_accept) begin
            w_nextCount = r_wrCount + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            r_wrCount <= '0;
        end else begin
            r_wrCount <= w_nextCount;
        end
    end

    // Every slot is rewritten before each emit, so the buffer needs no reset.
    always_ff @(posedge clk_100MHz) begin
        if (w_accept) begin
            r_wrBuf[w_wrAddr] <= w_shifted;
        end
    end

    // The final sample is bypassed straight into its slot so the frame emits next cycle.
    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            r_frameData  <= '0;
            r_frameValid <= 1'b0;
        end else begin
            r_frameValid <= w_lastAccept;
            if (w_lastAccept) begin
                for (int k = 0; k < N_PTS; k++) begin
                    if (IDX_W'(k) == w_wrAddr) begin
                        r_frameData[k*DATA_W +: DATA_W] <= w_shifted;
                    end else begin
                        r_frameData[k*DATA_W +: DATA_W] <= r_wrBuf[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz or negedge rstn) begin
        if (!rstn) begin
            r_frameErr <= 1'b0;
        end else if (w_sofRestart) begin
            r_frameErr <= 1'b1;
        end else if (clr_err) begin
            r_frameErr <= 1'b0;
        end
    end

    assign s_ready     = w_ready;
    assign frame_data  = r_frameData;
    assign frame_valid = r_frameValid;
    assign wr_count    = r_wrCount;
    assign frame_err   = r_frameErr;

endmodule

// File: tb/tb_fft_input_framer.sv
// Directed bench for fft_input_framer: a PRESHIFT=0 instance plus a PRESHIFT=1
// instance sharing the same input stream.
module tb_fft_input_framer;

    logic                clk_100MHz = 1'b0;
    logic                rstn = 1'b0;
    logic signed [15:0]  s_data = '0;
    logic                s_valid = 1'b0;
    logic                s_sof = 1'b0;
    logic                clr_err = 1'b0;

    logic                s_ready;
    logic [511:0]        frame_data;
    logic                frame_valid;
    logic [5:0]          wr_count;
    logic                frame_err;

    logic                shiftReady;
    logic [511:0]        shiftFrameData;
    logic                shiftFrameValid;
    logic [5:0]          shiftWrCount;
    logic                shiftFrameErr;

    int vectorCount = 0;
    int missCount = 0;
    int cycleCnt = 0;
    int pulseCount = 0;
    int lastPulseCycle = 0;
    int prevPulseCycle = 0;
    logic [15:0] expSample [32];

    fft_input_framer #(.N_PTS(32), .DATA_W(16), .PRESHIFT(0)) dut (
        .clk_100MHz (clk_100MHz),
        .rstn       (rstn),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_sof      (s_sof),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .wr_count   (wr_count),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    fft_input_framer #(.N_PTS(32), .DATA_W(16), .PRESHIFT(1)) dutShift (
        .clk_100MHz (clk_100MHz),
        .rstn       (rstn),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (shiftReady),
        .s_sof      (s_sof),
        .frame_data (shiftFrameData),
        .frame_valid(shiftFrameValid),
        .wr_count   (shiftWrCount),
        .frame_err  (shiftFrameErr),
        .clr_err    (clr_err)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // Cycle counter and frame_valid pulse log, sampled away from the active edge.
    always @(posedge clk_100MHz) cycleCnt <= cycleCnt + 1;

    always @(negedge clk_100MHz) begin
        if (frame_valid) begin
            pulseCount     <= pulseCount + 1;
            prevPulseCycle <= lastPulseCycle;
            lastPulseCycle <= cycleCnt;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] d, input logic sof, input logic clr);
        s_valid = v;
        s_data  = d;
        s_sof   = sof;
        clr_err = clr;
        @(posedge clk_100MHz);
        #1;
    endtask

    function automatic int bitRev5(input int k);
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (k[b]) r = r | (1 << (4 - b));
        end
        return r;
    endfunction

    function automatic logic [15:0] slotOf(input logic [511:0] bus, input int k);
        return bus[k*16 +: 16];
    endfunction

    task automatic checkFrame(input string tag);
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("%s slot%0d", tag, k), 32'(slotOf(frame_data, k)), 32'(expSample[bitRev5(k)]));
        end
    endtask

    task automatic streamFrame();
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, expSample[i], i == 0, 1'b0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        int accepted;
        int guard;
        logic v;
        logic [15:0] d;

        // Reset state
        #12;
        checkOutput("rst frame_data", 32'(frame_data == '0), 32'd1);
        checkOutput("rst frame_valid", 32'(frame_valid), 32'd0);
        checkOutput("rst wr_count", 32'(wr_count), 32'd0);
        checkOutput("rst frame_err", 32'(frame_err), 32'd0);
        checkOutput("rst s_ready", 32'(s_ready), 32'd0);
        rstn = 1'b1;
        #1;
        checkOutput("idle s_ready", 32'(s_ready), 32'd0);
        @(posedge clk_100MHz);
        #1;
        checkOutput("fill s_ready", 32'(s_ready), 32'd1);

        // Test 1: gapless ramp 0..31
        for (int i = 0; i < 32; i++) expSample[i] = 16'(i);
        p0 = pulseCount;
        for (int i = 0; i < 31; i++) applyStimulus(1'b1, expSample[i], i == 0, 1'b0);
        checkOutput("t1 valid before last", 32'(frame_valid), 32'd0);
        checkOutput("t1 wr_count 31", 32'(wr_count), 32'd31);
        applyStimulus(1'b1, expSample[31], 1'b0, 1'b0);
        checkOutput("t1 valid", 32'(frame_valid), 32'd1);
        checkOutput("t1 wr_count wrap", 32'(wr_count), 32'd0);
        checkOutput("t1 slot0", 32'(slotOf(frame_data, 0)), 32'd0);
        checkOutput("t1 slot1", 32'(slotOf(frame_data, 1)), 32'd16);
        checkOutput("t1 slot2", 32'(slotOf(frame_data, 2)), 32'd8);
        checkOutput("t1 slot3", 32'(slotOf(frame_data, 3)), 32'd24);
        checkOutput("t1 slot16", 32'(slotOf(frame_data, 16)), 32'd1);
        checkOutput("t1 slot31", 32'(slotOf(frame_data, 31)), 32'd31);
        checkFrame("t1");
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("t1 valid drop", 32'(frame_valid), 32'd0);
        checkOutput("t1 pulse count", 32'(pulseCount - p0), 32'd1);

        // Test 2: back-to-back frames A = 100+i, B = -i
        p0 = pulseCount;
        for (int i = 0; i < 64; i++) begin
            d = (i < 32) ? 16'(100 + i) : 16'(-(i - 32));
            if (i >= 32) expSample[i-32] = d;
            applyStimulus(1'b1, d, (i == 0) || (i == 32), 1'b0);
            if (i == 31) checkOutput("t2 valid A", 32'(frame_valid), 32'd1);
            if (i == 41) checkOutput("t2 slot1 holds A", 32'(slotOf(frame_data, 1)), 32'd116);
            if (i == 41) checkOutput("t2 valid mid B", 32'(frame_valid), 32'd0);
        end
        checkOutput("t2 valid B", 32'(frame_valid), 32'd1);
        checkOutput("t2 slot1 B", 32'(slotOf(frame_data, 1)), 32'h0000FFF0);
        checkOutput("t2 slot16 B", 32'(slotOf(frame_data, 16)), 32'h0000FFFF);
        checkFrame("t2");
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("t2 pulse count", 32'(pulseCount - p0), 32'd2);
        checkOutput("t2 pulse spacing", 32'(lastPulseCycle - prevPulseCycle), 32'd32);

        // Test 3: random s_valid gaps, same ramp as test 1
        for (int i = 0; i < 32; i++) expSample[i] = 16'(i);
        p0 = pulseCount;
        accepted = 0;
        guard = 0;
        while (accepted < 32 && guard < 2000) begin
            v = 1'($urandom_range(0, 1));
            applyStimulus(v, expSample[accepted], accepted == 0, 1'b0);
            if (v) accepted++;
            guard++;
        end
        checkOutput("t3 accepts", 32'(accepted), 32'd32);
        checkOutput("t3 valid", 32'(frame_valid), 32'd1);
        checkFrame("t3");
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("t3 pulse count", 32'(pulseCount - p0), 32'd1);

        // Test 4: s_sof mid-frame discards the partial frame
        p0 = pulseCount;
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 16'(50 + i), i == 0, 1'b0);
        checkOutput("t4 wr_count 10", 32'(wr_count), 32'd10);
        checkOutput("t4 err before", 32'(frame_err), 32'd0);
        applyStimulus(1'b1, 16'd7, 1'b1, 1'b0);
        checkOutput("t4 err set", 32'(frame_err), 32'd1);
        checkOutput("t4 wr_count restart", 32'(wr_count), 32'd1);
        checkOutput("t4 frame undisturbed", 32'(slotOf(frame_data, 1)), 32'd16);
        for (int j = 1; j < 32; j++) applyStimulus(1'b1, 16'(200 + j), 1'b0, 1'b0);
        checkOutput("t4 valid", 32'(frame_valid), 32'd1);
        checkOutput("t4 slot0", 32'(slotOf(frame_data, 0)), 32'd7);
        checkOutput("t4 slot16", 32'(slotOf(frame_data, 16)), 32'd201);
        checkOutput("t4 slot31", 32'(slotOf(frame_data, 31)), 32'd231);
        checkOutput("t4 err sticky", 32'(frame_err), 32'd1);
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
        checkOutput("t4 err cleared", 32'(frame_err), 32'd0);
        checkOutput("t4 pulse count", 32'(pulseCount - p0), 32'd1);

        // Test 5: -3 everywhere; PRESHIFT=1 instance must give -2
        for (int i = 0; i < 32; i++) expSample[i] = 16'hFFFD;
        streamFrame();
        checkOutput("t5 shift valid", 32'(shiftFrameValid), 32'd1);
        for (int k = 0; k < 32; k++) begin
            checkOutput($sformatf("t5 shift slot%0d", k), 32'(slotOf(shiftFrameData, k)), 32'h0000FFFE);
        end
        checkFrame("t5 noshift");
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);

        // Set and clear of frame_err in the same cycle: set wins
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(i), i == 0, 1'b0);
        applyStimulus(1'b1, 16'd9, 1'b1, 1'b1);
        checkOutput("sw err set wins", 32'(frame_err), 32'd1);
        checkOutput("sw wr_count", 32'(wr_count), 32'd1);

        // Test 6: asynchronous reset mid-frame
        for (int i = 0; i < 19; i++) applyStimulus(1'b1, 16'(500 + i), 1'b0, 1'b0);
        checkOutput("t6 wr_count 20", 32'(wr_count), 32'd20);
        s_valid = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        checkOutput("t6 frame zero", 32'(frame_data == '0), 32'd1);
        checkOutput("t6 shift frame zero", 32'(shiftFrameData == '0), 32'd1);
        checkOutput("t6 valid", 32'(frame_valid), 32'd0);
        checkOutput("t6 wr_count", 32'(wr_count), 32'd0);
        checkOutput("t6 err", 32'(frame_err), 32'd0);
        checkOutput("t6 s_ready", 32'(s_ready), 32'd0);
        #2;
        rstn = 1'b1;
        @(posedge clk_100MHz);
        #1;
        checkOutput("t6 s_ready back", 32'(s_ready), 32'd1);
        for (int i = 0; i < 32; i++) expSample[i] = 16'(300 + i);
        p0 = pulseCount;
        streamFrame();
        checkOutput("t6 valid after", 32'(frame_valid), 32'd1);
        checkFrame("t6");
        applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
        checkOutput("t6 pulse count", 32'(pulseCount - p0), 32'd1);
        checkOutput("t6 wr_count end", 32'(wr_count), 32'd0);
        checkOutput("t6 shift wr_count end", 32'(shiftWrCount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
